// File: rtl/alu_pkg.sv
// Shared definitions for the custom ALU blocks: divider FSM states and
// divider constants.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int          DIV_STEPS  = 8;
    localparam int          DIV_CNT_W  = 4;
    localparam logic [7:0]  DIV_ZERO_Q = 8'hFF;

endpackage

// File: rtl/addsub_8bit.sv
// 8-bit adder/subtractor: Sel=0 gives A+B, Sel=1 gives A-B as A+~B+1.
// Cout is the carry out; in subtract mode Cout=1 means no borrow (A >= B).
module addsub_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Sel,
    output logic [7:0] Y,
    output logic       Cout
);

    logic [8:0] sum_s;

    // Two's-complement add with the select bit as both invert mask and carry-in
    always_comb begin
        sum_s = {1'b0, A} + {1'b0, B ^ {8{Sel}}} + {8'd0, Sel};
        Y     = sum_s[7:0];
        Cout  = sum_s[8];
    end

endmodule

// File: rtl/div_8bit_seq.sv
// Sequential unsigned 8-bit restoring divider built around addsub_8bit.
// One quotient bit per cycle, then a finalize cycle, then a one-cycle done pulse.
module div_8bit_seq
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       busy,
    output logic       done,
    output logic       div_zero
);

    // Counter runs 0..DIV_STEPS-1 for the iterations; DIV_STEPS marks the
    // finalize cycle. A zero divisor jumps straight to it.
    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_STEPS);

    div_state_t            state_r;
    div_state_t            state_next_s;
    logic [DIV_CNT_W-1:0]  cnt_r;
    logic [7:0]            dividend_r;
    logic [7:0]            divisor_r;
    logic [7:0]            p_r;
    logic [7:0]            quot_r;
    logic [7:0]            q_r;
    logic [7:0]            r_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  div_zero_r;

    logic [8:0]            t_s;
    logic [7:0]            diff_s;
    logic                  cout_s;
    logic                  qbit_s;
    logic [7:0]            p_step_s;

    addsub_8bit u_sub (
        .A    (t_s[7:0]),
        .B    (divisor_r),
        .Sel  (1'b1),
        .Y    (diff_s),
        .Cout (cout_s)
    );

    // One restoring step: T[8] set means T already exceeds any 8-bit divisor
    always_comb begin
        t_s      = {p_r, dividend_r[7]};
        qbit_s   = t_s[8] | cout_s;
        p_step_s = qbit_s ? diff_s : t_s[7:0];
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = CALC;
                else       state_next_s = IDLE;
            end
            CALC: begin
                if (cnt_r == LAST_CNT) state_next_s = DONE;
                else                   state_next_s = CALC;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Handshake outputs registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_next_s == DONE);
        end
    end

    // Datapath: operand capture, shift-subtract iterations, result transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            dividend_r <= 8'd0;
            divisor_r  <= 8'd0;
            p_r        <= 8'd0;
            quot_r     <= 8'd0;
            q_r        <= 8'd0;
            r_r        <= 8'd0;
            div_zero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dividend_r <= A;
                        divisor_r  <= B;
                        p_r        <= 8'd0;
                        quot_r     <= 8'd0;
                        div_zero_r <= 1'b0;
                        cnt_r      <= (B == 8'd0) ? LAST_CNT : '0;
                    end
                end
                CALC: begin
                    if (cnt_r == LAST_CNT) begin
                        // A captured zero divisor is the only way divisor_r is 0 here
                        if (divisor_r == 8'd0) begin
                            q_r        <= DIV_ZERO_Q;
                            r_r        <= dividend_r;
                            div_zero_r <= 1'b1;
                        end else begin
                            q_r <= quot_r;
                            r_r <= p_r;
                        end
                    end else begin
                        p_r        <= p_step_s;
                        dividend_r <= {dividend_r[6:0], 1'b0};
                        quot_r     <= {quot_r[6:0], qbit_s};
                        cnt_r      <= cnt_r + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign Q        = q_r;
    assign R        = r_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

endmodule
